// File: rtl/controlador_seleccion.sv
// controlador_seleccion: debounces the player buttons, runs the character
// selection FSM (00 none, 01 Rick, 10 Morty) and moves the chosen sprite
// once per frame, during vertical blanking, clamped to the visible screen.
module controlador_seleccion #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int SPRITE_W        = 32,
   parameter int SPRITE_H        = 32,
   parameter int STEP            = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       boton_sel,
   input  logic       boton_ok,
   input  logic       boton_izq,
   input  logic       boton_der,
   input  logic       boton_arr,
   input  logic       boton_aba,
   input  logic [9:0] cuentaX,
   input  logic [9:0] cuentaY,
   output logic [1:0] contador_seleccionador,
   output logic [9:0] posX,
   output logic [9:0] posY,
   output logic       jugando
);

   localparam int         CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - SPRITE_W);
   localparam logic [9:0] Y_MAX    = 10'(V_ACTIVE - SPRITE_H);
   localparam logic [9:0] X_CENTER = 10'((H_ACTIVE - SPRITE_W) / 2);
   localparam logic [9:0] Y_CENTER = 10'((V_ACTIVE - SPRITE_H) / 2);

   typedef enum logic [1:0] {IDLE, ELIGE_RICK, ELIGE_MORTY, JUGANDO} state_t;

   // Button index: 0 sel, 1 ok, 2 izq, 3 der, 4 arr, 5 aba
   logic [5:0] w_raw;
   logic [5:0] w_level;
   assign w_raw = {boton_aba, boton_arr, boton_der, boton_izq, boton_ok, boton_sel};

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         logic          r_sync1;
         logic          r_sync2;
         logic          r_level;
         logic [CW-1:0] r_cnt;

         // Two-flop synchronizer, then accept a new level only after
         // DEBOUNCE_CYCLES consecutive differing samples
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_level <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_raw[gi];
               r_sync2 <= r_sync1;
               if (r_sync2 == r_level) begin
                  r_cnt <= '0;
               end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  r_level <= r_sync2;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_level[gi] = r_level;
      end
   endgenerate

   logic [1:0] r_lvl_prev;
   logic [1:0] r_pulse;
   logic       w_sel_pulse;
   logic       w_ok_pulse;

   // Registered rising-edge detect on the debounced sel/ok levels
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lvl_prev <= 2'b00;
         r_pulse    <= 2'b00;
      end else begin
         r_lvl_prev <= w_level[1:0];
         r_pulse    <= w_level[1:0] & ~r_lvl_prev;
      end
   end

   assign w_sel_pulse = r_pulse[0];
   assign w_ok_pulse  = r_pulse[1];

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_sel;
   logic [1:0] w_sel_next;
   logic       r_jugando;
   logic [9:0] r_pos_x;
   logic [9:0] r_pos_y;

   // Next state and selection code; ok takes priority over sel
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      case (r_state)
         IDLE: begin
            if (w_sel_pulse) begin
               w_state_next = ELIGE_RICK;
               w_sel_next   = 2'b01;
            end
         end
         ELIGE_RICK: begin
            if (w_ok_pulse) begin
               w_state_next = JUGANDO;
            end else if (w_sel_pulse) begin
               w_state_next = ELIGE_MORTY;
               w_sel_next   = 2'b10;
            end
         end
         ELIGE_MORTY: begin
            if (w_ok_pulse) begin
               w_state_next = JUGANDO;
            end else if (w_sel_pulse) begin
               w_state_next = ELIGE_RICK;
               w_sel_next   = 2'b01;
            end
         end
         JUGANDO: begin
            if (w_ok_pulse) begin
               w_state_next = IDLE;
               w_sel_next   = 2'b00;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_sel_next   = 2'b00;
         end
      endcase
   end

   logic               w_tick;
   logic               w_entry;
   logic signed [10:0] w_dx;
   logic signed [10:0] w_dy;
   logic signed [10:0] w_x_sum;
   logic signed [10:0] w_y_sum;
   logic [9:0]         w_pos_x_next;
   logic [9:0]         w_pos_y_next;

   assign w_tick  = (cuentaX == 10'd0) && (cuentaY == 10'(V_ACTIVE));
   assign w_entry = (r_state != JUGANDO) && (w_state_next == JUGANDO);

   // Signed step, saturating add and recenter-on-entry for the sprite position
   always_comb begin
      w_dx = 11'sd0;
      w_dy = 11'sd0;
      if (w_level[3] && !w_level[2]) w_dx = 11'(STEP);
      else if (w_level[2] && !w_level[3]) w_dx = -(11'(STEP));
      if (w_level[5] && !w_level[4]) w_dy = 11'(STEP);
      else if (w_level[4] && !w_level[5]) w_dy = -(11'(STEP));
      w_x_sum = $signed({1'b0, r_pos_x}) + w_dx;
      w_y_sum = $signed({1'b0, r_pos_y}) + w_dy;

      w_pos_x_next = r_pos_x;
      w_pos_y_next = r_pos_y;
      if (w_entry) begin
         w_pos_x_next = X_CENTER;
         w_pos_y_next = Y_CENTER;
      end else if ((r_state == JUGANDO) && w_tick) begin
         if (w_x_sum < 11'sd0)                         w_pos_x_next = 10'd0;
         else if (w_x_sum > $signed({1'b0, X_MAX}))    w_pos_x_next = X_MAX;
         else                                          w_pos_x_next = w_x_sum[9:0];
         if (w_y_sum < 11'sd0)                         w_pos_y_next = 10'd0;
         else if (w_y_sum > $signed({1'b0, Y_MAX}))    w_pos_y_next = Y_MAX;
         else                                          w_pos_y_next = w_y_sum[9:0];
      end
   end

   // State, selection code, play flag and position registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_sel     <= 2'b00;
         r_jugando <= 1'b0;
         r_pos_x   <= X_CENTER;
         r_pos_y   <= Y_CENTER;
      end else begin
         r_state   <= w_state_next;
         r_sel     <= w_sel_next;
         r_jugando <= (w_state_next == JUGANDO);
         r_pos_x   <= w_pos_x_next;
         r_pos_y   <= w_pos_y_next;
      end
   end

   assign contador_seleccionador = r_sel;
   assign jugando                = r_jugando;
   assign posX                   = r_pos_x;
   assign posY                   = r_pos_y;

endmodule

// File: tb/tb_controlador_seleccion.sv
// Directed testbench for controlador_seleccion with DEBOUNCE_CYCLES = 4.
module tb_controlador_seleccion;

   logic       clk = 1'b0;
   logic       rst;
   logic       boton_sel, boton_ok, boton_izq, boton_der, boton_arr, boton_aba;
   logic [9:0] cuentaX, cuentaY;
   logic [1:0] contador_seleccionador;
   logic [9:0] posX, posY;
   logic       jugando;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   controlador_seleccion #(.DEBOUNCE_CYCLES(4)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .boton_sel              (boton_sel),
      .boton_ok               (boton_ok),
      .boton_izq              (boton_izq),
      .boton_der              (boton_der),
      .boton_arr              (boton_arr),
      .boton_aba              (boton_aba),
      .cuentaX                (cuentaX),
      .cuentaY                (cuentaY),
      .contador_seleccionador (contador_seleccionador),
      .posX                   (posX),
      .posY                   (posY),
      .jugando                (jugando)
   );

   // Advance n active edges and settle 1 time unit past the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_sel();
      boton_sel = 1'b1; cyc(10);
      boton_sel = 1'b0; cyc(10);
   endtask

   task automatic press_ok();
      boton_ok = 1'b1; cyc(10);
      boton_ok = 1'b0; cyc(10);
   endtask

   // One-cycle frame tick (cuentaX=0, cuentaY=480); returns 1 unit after the sampling edge
   task automatic frame();
      cuentaX = 10'd0; cuentaY = 10'd480;
      cyc(1);
      cuentaX = 10'd1; cuentaY = 10'd0;
   endtask

   task automatic do_reset();
      rst = 1'b0; cyc(2);
      rst = 1'b1; cyc(1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      {boton_sel, boton_ok, boton_izq, boton_der, boton_arr, boton_aba} = '0;
      cuentaX = 10'd1; cuentaY = 10'd0;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      checks++;
      if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd304 || posY !== 10'd224) begin
         failures++;
         $display("FAIL reset_values sel=%b jug=%b x=%0d y=%0d required sel=00 jug=0 x=304 y=224",
                  contador_seleccionador, jugando, posX, posY);
      end
      for (int i = 0; i < 1000; i++) begin
         cuentaX = 10'(i % 4); cuentaY = 10'd480;
         cyc(1);
         checks++;
         if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd304 || posY !== 10'd224) begin
            failures++;
            $display("FAIL reset_idle_hold cycle=%0d sel=%b jug=%b x=%0d y=%0d required 00/0/304/224",
                     i, contador_seleccionador, jugando, posX, posY);
         end
      end
      cuentaX = 10'd1; cuentaY = 10'd0;
      $display("test_reset done");
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 10; i++) begin
         boton_sel = ~boton_sel;
         cyc(2);
         checks++;
         if (contador_seleccionador !== 2'b00) begin
            failures++;
            $display("FAIL bounce_no_pulse step=%0d sel=%b required 00", i, contador_seleccionador);
         end
      end
      boton_sel = 1'b1;
      cyc(7);
      checks++;
      if (contador_seleccionador !== 2'b00) begin
         failures++;
         $display("FAIL bounce_too_early sel=%b required 00", contador_seleccionador);
      end
      cyc(1);
      checks++;
      if (contador_seleccionador !== 2'b01) begin
         failures++;
         $display("FAIL bounce_latency8 sel=%b required 01", contador_seleccionador);
      end
      cyc(20);
      checks++;
      if (contador_seleccionador !== 2'b01) begin
         failures++;
         $display("FAIL bounce_single_pulse sel=%b required 01", contador_seleccionador);
      end
      boton_sel = 1'b0; cyc(10);
      boton_sel = 1'b1; cyc(3);
      boton_sel = 1'b0; cyc(12);
      checks++;
      if (contador_seleccionador !== 2'b01) begin
         failures++;
         $display("FAIL glitch_3cycle sel=%b required 01", contador_seleccionador);
      end
      $display("test_bounce done");
   endtask

   task automatic test_selection();
      logic [1:0] exp_seq [3];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press_sel();
         checks++;
         if (contador_seleccionador !== exp_seq[i] || jugando !== 1'b0) begin
            failures++;
            $display("FAIL select_press%0d sel=%b jug=%b required sel=%b jug=0",
                     i, contador_seleccionador, jugando, exp_seq[i]);
         end
      end
      press_ok();
      checks++;
      if (jugando !== 1'b1 || contador_seleccionador !== 2'b01 || posX !== 10'd304 || posY !== 10'd224) begin
         failures++;
         $display("FAIL select_ok jug=%b sel=%b x=%0d y=%0d required 1/01/304/224",
                  jugando, contador_seleccionador, posX, posY);
      end
      press_sel();
      press_sel();
      checks++;
      if (jugando !== 1'b1 || contador_seleccionador !== 2'b01) begin
         failures++;
         $display("FAIL select_ignored_in_play jug=%b sel=%b required 1/01", jugando, contador_seleccionador);
      end
      $display("test_selection done");
   endtask

   task automatic test_movement();
      boton_der = 1'b1; cyc(10);
      for (int k = 1; k <= 3; k++) begin
         frame();
         checks++;
         if (posX !== 10'(304 + 2 * k) || posY !== 10'd224) begin
            failures++;
            $display("FAIL move_der frame=%0d x=%0d y=%0d required x=%0d y=224", k, posX, posY, 304 + 2 * k);
         end
         cyc(1);
      end
      // Near-miss tick positions must not move the sprite
      cuentaX = 10'd0; cuentaY = 10'd479; cyc(1);
      cuentaX = 10'd1; cuentaY = 10'd480; cyc(1);
      cuentaX = 10'd1; cuentaY = 10'd0;   cyc(1);
      checks++;
      if (posX !== 10'd310) begin
         failures++;
         $display("FAIL move_not_tick x=%0d required 310", posX);
      end
      boton_izq = 1'b1; cyc(10);
      frame();
      checks++;
      if (posX !== 10'd310) begin
         failures++;
         $display("FAIL move_izq_der_cancel x=%0d required 310", posX);
      end
      boton_der = 1'b0; cyc(10);
      frame();
      checks++;
      if (posX !== 10'd308) begin
         failures++;
         $display("FAIL move_izq x=%0d required 308", posX);
      end
      boton_izq = 1'b0; cyc(10);
      boton_aba = 1'b1; cyc(10);
      frame();
      checks++;
      if (posY !== 10'd226 || posX !== 10'd308) begin
         failures++;
         $display("FAIL move_aba x=%0d y=%0d required x=308 y=226", posX, posY);
      end
      boton_aba = 1'b0; cyc(10);
      $display("test_movement done");
   endtask

   task automatic test_clamp();
      int exp_x;
      int exp_y;
      exp_x = 308;
      exp_y = 226;
      boton_der = 1'b1; cyc(10);
      for (int i = 0; i < 200; i++) begin
         frame();
         exp_x = (exp_x + 2 > 608) ? 608 : exp_x + 2;
         checks++;
         if (posX !== 10'(exp_x)) begin
            failures++;
            $display("FAIL clamp_x frame=%0d x=%0d required %0d", i, posX, exp_x);
         end
         cyc(1);
      end
      boton_der = 1'b0; cyc(10);
      boton_arr = 1'b1; cyc(10);
      for (int i = 0; i < 200; i++) begin
         frame();
         exp_y = (exp_y - 2 < 0) ? 0 : exp_y - 2;
         checks++;
         if (posY !== 10'(exp_y)) begin
            failures++;
            $display("FAIL clamp_y frame=%0d y=%0d required %0d", i, posY, exp_y);
         end
         cyc(1);
      end
      boton_arr = 1'b0; cyc(10);
      checks++;
      if (posX !== 10'd608 || posY !== 10'd0) begin
         failures++;
         $display("FAIL clamp_final x=%0d y=%0d required x=608 y=0", posX, posY);
      end
      $display("test_clamp done");
   endtask

   task automatic test_simultaneous_exit();
      press_ok();
      checks++;
      if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd608 || posY !== 10'd0) begin
         failures++;
         $display("FAIL exit_to_idle sel=%b jug=%b x=%0d y=%0d required 00/0/608/0",
                  contador_seleccionador, jugando, posX, posY);
      end
      boton_izq = 1'b1; cyc(10);
      frame();
      checks++;
      if (posX !== 10'd608) begin
         failures++;
         $display("FAIL idle_no_move x=%0d required 608", posX);
      end
      boton_izq = 1'b0; cyc(10);
      press_sel();
      press_sel();
      checks++;
      if (contador_seleccionador !== 2'b10) begin
         failures++;
         $display("FAIL morty_select sel=%b required 10", contador_seleccionador);
      end
      boton_sel = 1'b1; boton_ok = 1'b1; cyc(10);
      boton_sel = 1'b0; boton_ok = 1'b0; cyc(10);
      checks++;
      if (jugando !== 1'b1 || contador_seleccionador !== 2'b10 || posX !== 10'd304 || posY !== 10'd224) begin
         failures++;
         $display("FAIL sel_ok_same_cycle jug=%b sel=%b x=%0d y=%0d required 1/10/304/224",
                  jugando, contador_seleccionador, posX, posY);
      end
      boton_der = 1'b1; cyc(10);
      frame();
      boton_der = 1'b0; cyc(10);
      press_ok();
      checks++;
      if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd306 || posY !== 10'd224) begin
         failures++;
         $display("FAIL exit_hold_pos sel=%b jug=%b x=%0d y=%0d required 00/0/306/224",
                  contador_seleccionador, jugando, posX, posY);
      end
      press_sel();
      // Asynchronous reset between clock edges
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd304 || posY !== 10'd224) begin
         failures++;
         $display("FAIL async_reset sel=%b jug=%b x=%0d y=%0d required 00/0/304/224",
                  contador_seleccionador, jugando, posX, posY);
      end
      cyc(2);
      rst = 1'b1;
      cyc(2);
      checks++;
      if (contador_seleccionador !== 2'b00 || jugando !== 1'b0 || posX !== 10'd304 || posY !== 10'd224) begin
         failures++;
         $display("FAIL after_async_reset sel=%b jug=%b x=%0d y=%0d required 00/0/304/224",
                  contador_seleccionador, jugando, posX, posY);
      end
      $display("test_simultaneous_exit done");
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_selection();
      test_movement();
      test_clamp();
      test_simultaneous_exit();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit reached");
   end

endmodule
